// File: rtl/mlp_seq_classifier.sv
// Time-multiplexed two-layer binary-input MLP: one signed MAC per cycle, loadable weights, running argmax.
// Build option: define MLP_MARGIN_EN to track the second-best score and report the top-1/top-2 margin.
module mlp_seq_classifier #(
  parameter int N_IN  = 7,
  parameter int N_HID = 3,
  parameter int N_OUT = 10,
  parameter int W_W   = 12,
  parameter int ACC_W = 20,
  localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_IN-1:0]         x,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [W_W-1:0]   wr_data,
  output logic                    wr_drop,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [CW-1:0]           class_id,
  output logic signed [ACC_W-1:0] margin
);

  localparam int OUT_BASE = N_HID * (N_IN + 1);
  localparam int CNT_MAX  = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int IDX_MAX  = (N_OUT > N_HID) ? N_OUT : N_HID;
  localparam int IDX_W    = $clog2(IDX_MAX);

  typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic signed [W_W-1:0]   mem [DEPTH];
  logic [AW-1:0]           rd_addr;
  logic signed [ACC_W-1:0] wext, hsel, term, sum, acc;
  logic signed [ACC_W-1:0] h [N_HID];
  logic signed [ACC_W-1:0] best, best_n;
  logic [CW-1:0]           best_idx, bidx_n;
  logic [N_IN-1:0]         x_q;
  logic                    xbit, wr_ok, last_term;
`ifdef MLP_MARGIN_EN
  logic signed [ACC_W-1:0] second, sec_n;
`endif

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? '0 : v;
  endfunction

  // Weight memory has no reset so contents survive rst_n.
  assign wr_ok = wr_en && (state == S_IDLE) && (int'(wr_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_addr = '0;
    if (state == S_L1)
      rd_addr = AW'(int'(idx) * (N_IN + 1) + int'(cnt));
    else if (state == S_L2)
      rd_addr = AW'(OUT_BASE + int'(idx) * (N_HID + 1) + int'(cnt));
  end

  // Offset 0 of every neuron is its bias; offset 1+n multiplies input n.
  always_comb begin
    xbit = 1'b0;
    hsel = '0;
    for (int i = 0; i < N_IN; i++)
      if (int'(cnt) == i + 1) xbit = x_q[i];
    for (int j = 0; j < N_HID; j++)
      if (int'(cnt) == j + 1) hsel = h[j];
    wext = ACC_W'(mem[rd_addr]);
    if (cnt == '0)
      term = wext;
    else if (state == S_L1)
      term = xbit ? wext : '0;
    else
      term = wext * hsel;
    sum       = ((cnt == '0) ? '0 : acc) + term;
    last_term = (state == S_L1) ? (int'(cnt) == N_IN) : (int'(cnt) == N_HID);
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    best_n = best;
    bidx_n = best_idx;
`ifdef MLP_MARGIN_EN
    sec_n  = second;
`endif
    if (idx == '0) begin
      best_n = sum;
      bidx_n = '0;
    end else if (sum > best) begin
`ifdef MLP_MARGIN_EN
      sec_n  = best;
`endif
      best_n = sum;
      bidx_n = CW'(idx);
    end
`ifdef MLP_MARGIN_EN
    else if ((idx == IDX_W'(1)) || (sum > second)) begin
      sec_n = sum;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      wr_drop  <= 1'b0;
      class_id <= '0;
`ifdef MLP_MARGIN_EN
      margin   <= '0;
`endif
    end else begin
      done    <= 1'b0;
      wr_drop <= wr_en && !wr_ok;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_L1;
            busy  <= 1'b1;
            valid <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        S_L1: begin
          if (last_term) begin
            cnt <= '0;
            if (int'(idx) == N_HID - 1) begin
              idx   <= '0;
              state <= S_L2;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_L2: begin
          if (last_term) begin
            cnt <= '0;
            if (int'(idx) == N_OUT - 1) begin
              state    <= S_DONE;
              done     <= 1'b1;
              valid    <= 1'b1;
              class_id <= bidx_n;
`ifdef MLP_MARGIN_EN
              margin   <= best_n - sec_n;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef MLP_MARGIN_EN
  assign margin = '0;
`endif

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) x_q <= x;
    if ((state == S_L1) || (state == S_L2)) acc <= sum;
    if ((state == S_L1) && last_term)
      for (int j = 0; j < N_HID; j++)
        if (int'(idx) == j) h[j] <= relu(sum);
    if ((state == S_L2) && last_term) begin
      best     <= best_n;
      best_idx <= bidx_n;
`ifdef MLP_MARGIN_EN
      second   <= sec_n;
`endif
    end
  end

endmodule

// File: tb/tb_mlp_seq_classifier.sv
// Self-checking bench for mlp_seq_classifier: behavioural reference model plus per-cycle output compare.
module tb_mlp_seq_classifier;
  localparam int N_IN  = 7;
  localparam int N_HID = 3;
  localparam int N_OUT = 10;
  localparam int W_W   = 12;
  localparam int ACC_W = 20;
  localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N_OUT);
  localparam int LAT   = DEPTH + 1;
`ifdef MLP_MARGIN_EN
  localparam int MG_A = 4;
  localparam int MG_D = 80;
`else
  localparam int MG_A = 0;
  localparam int MG_D = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_en = 1'b0;
  logic [N_IN-1:0] x = '0;
  logic [AW-1:0] wr_addr = '0;
  logic signed [W_W-1:0] wr_data = '0;
  logic wr_drop, busy, done, valid;
  logic [CW-1:0] class_id;
  logic signed [ACC_W-1:0] margin;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mlp_seq_classifier #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_drop(wr_drop), .busy(busy), .done(done), .valid(valid),
    .class_id(class_id), .margin(margin));

  int tbl_hid[24] = '{0, -3, -5, 0, 4, -1, 0, -2,
                      5, 28, 19, -24, 15, 37, -37, 29,
                      9, 23, 36, 32, -9, 3, -28, -30};
  int tbl_out[40] = '{-180, -6, -1, 23,   100, 1, 2, 3,    -50, 4, -2, 10,
                      200, 0, 10, 5,      400, 3, 5, 0,    0, 0, 0, 0,
                      300, -2, 6, 8,      -400, 9, 9, 9,   410, 0, 1, -1,
                      350, -1, 7, 4};

  // Reference model state
  int     m_mem[DEPTH];
  bit     m_run = 1'b0;
  int     m_e = 0;
  longint cyc = 0, acc_cyc = 0, done_cyc = 0;
  int     done_cnt = 0;
  bit     exp_busy = 1'b0, exp_done = 1'b0, exp_valid = 1'b0, exp_drop = 1'b0;
  int     exp_class = 0, pend_class = 0;
  longint exp_margin = 0, pend_margin = 0;

  function automatic longint wrap(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return t;
  endfunction

  function automatic void model_infer(input logic [N_IN-1:0] xv, output int cls, output longint mg);
    longint hv[N_HID];
    longint e[N_OUT];
    longint s, sec;
    bit have;
    int base;
    for (int j = 0; j < N_HID; j++) begin
      base = j * (N_IN + 1);
      s = m_mem[base];
      for (int i = 0; i < N_IN; i++)
        if (xv[i]) s += m_mem[base + 1 + i];
      s = wrap(s);
      hv[j] = (s < 0) ? 0 : s;
    end
    for (int k = 0; k < N_OUT; k++) begin
      base = N_HID * (N_IN + 1) + k * (N_HID + 1);
      s = m_mem[base];
      for (int j = 0; j < N_HID; j++) s += longint'(m_mem[base + 1 + j]) * hv[j];
      e[k] = wrap(s);
    end
    cls = 0;
    for (int k = 1; k < N_OUT; k++)
      if (e[k] > e[cls]) cls = k;
    have = 1'b0;
    sec = 0;
    for (int k = 0; k < N_OUT; k++)
      if (k != cls && (!have || e[k] > sec)) begin
        sec = e[k];
        have = 1'b1;
      end
    mg = wrap(e[cls] - sec);
`ifndef MLP_MARGIN_EN
    mg = 0;
`endif
  endfunction

  // Accept edge T: done is high in the cycle after edge T+LAT-1, idle again after edge T+LAT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_e = 0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_valid = 1'b0; exp_drop = 1'b0;
      exp_class = 0; exp_margin = 0;
    end else begin
      cyc++;
      exp_drop = wr_en && (m_run || int'(wr_addr) >= DEPTH);
      exp_done = 1'b0;
      if (!m_run) begin
        if (wr_en && int'(wr_addr) < DEPTH) m_mem[wr_addr] = int'(wr_data);
        if (start) begin
          m_run = 1'b1; m_e = 0;
          exp_busy = 1'b1; exp_valid = 1'b0;
          acc_cyc = cyc;
          model_infer(x, pend_class, pend_margin);
        end
      end else begin
        m_e++;
        if (m_e == LAT - 1) begin
          exp_done = 1'b1; exp_valid = 1'b1;
          exp_class = pend_class; exp_margin = pend_margin;
        end
        if (m_e == LAT) begin
          m_run = 1'b0; exp_busy = 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("valid", valid, exp_valid);
      check("wr_drop", wr_drop, exp_drop);
      check("class_id", class_id, exp_class);
      check("margin", margin, exp_margin);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [N_IN-1:0] xv);
    @(negedge clk);
    start = 1'b1; x = xv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr_then_start(input int a, input int d, input logic [N_IN-1:0] xv);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W_W'(d);
    @(negedge clk);
    wr_en = 1'b0; start = 1'b1; x = xv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s: no done within 200 cycles", nm);
    end
    #1;
  endtask

  task automatic load_table();
    for (int a = 0; a < 24; a++) wr(a, tbl_hid[a]);
    for (int a = 0; a < 40; a++) wr(24 + a, tbl_out[a]);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    longint first;
    int mode, dv;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_wr_drop", wr_drop, 0);
    check("rst_class", class_id, 0);
    check("rst_margin", margin, 0);
    rst_n = 1'b1;

    // Reference table, x=0: scores peak at e4=425 over e9=421.
    load_table();
    do_start('0);
    wait_done("run_a");
    check("a_latency", done_cyc - acc_cyc + 1, LAT);
    check("a_class", class_id, 4);
    check("a_margin", margin, MG_A);

    // Starts and a write while busy must be ignored/dropped.
    d0 = done_cnt;
    do_start('0);
    for (int c = 2; c < 100; c++) begin
      @(negedge clk);
      start = (c == 10 || c == 40);
      wr_en = (c == 20);
      wr_addr = AW'(9); wr_data = -12'sd777;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check("b_done_count", done_cnt - d0, 1);
    check("b_class", class_id, 4);

    // Asynchronous reset mid-inference; weights must survive.
    do_start('0);
    repeat (28) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("c_rst_busy", busy, 0);
    check("c_rst_valid", valid, 0);
    check("c_rst_class", class_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start('0);
    wait_done("run_c");
    check("c_class", class_id, 4);
    check("c_margin", margin, MG_A);

    // Back-to-back: start held high, x=0 then x=7F.
    @(negedge clk);
    start = 1'b1; x = '0;
    @(negedge clk);
    x = 7'h7F;
    wait_done("run_d1");
    first = done_cyc;
    @(negedge clk);
    wait_done("run_d2");
    start = 1'b0;
    check("d_spacing", done_cyc - first, 66);
    check("d_class", class_id, 3);
    check("d_margin", margin, MG_D);
    repeat (3) @(negedge clk);

    // All-zero weights: every score ties at 0.
    for (int a = 0; a < DEPTH; a++) wr(a, 0);
    do_start(N_IN'($urandom));
    wait_done("run_e");
    check("e_class", class_id, 0);
    check("e_margin", margin, 0);

    // Randomized weights, inputs and disturbances during busy.
    for (int it = 0; it < 12; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int a = 0; a < DEPTH - 1; a++) begin
        if (mode == 0) dv = int'($urandom_range(0, 4095)) - 2048;
        else if (mode == 1) dv = int'($urandom_range(0, 32)) - 16;
        else dv = int'($urandom_range(0, 6)) - 3;
        wr(a, dv);
      end
      wr_then_start(DEPTH - 1, int'($urandom_range(0, 200)) - 100, N_IN'($urandom));
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        wr_en = ($urandom_range(0, 2) == 0);
        wr_addr = AW'($urandom);
        wr_data = W_W'($urandom);
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      wait_done("run_rand");
      repeat (2) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
